// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in clk cycles.
// Latency: a pin edge is seen 3 clk later (plus FILT_LEN with PWM_FILTER_EN); meas_valid follows 1 clk after the closing rise.
// Backpressure: none. Results are a 1-cycle pulse, and outputs hold their values until the next report.
//
// Ports:
//   clk, rst_n   system clock (posedge) and asynchronous active-low reset
//   pwm_in       asynchronous PWM line
//   high_cnt     high time of the last completed period (saturating)
//   period_cnt   length of the last completed period (saturating)
//   meas_valid   1-cycle pulse when high_cnt/period_cnt are updated
//   stuck        no accepted edge for TIMEOUT cycles
//   stuck_lvl    line level while stuck
//   overflow     last reported period saturated the counter
// Optional: define PWM_FILTER_EN to add a FILT_LEN-cycle glitch filter after the synchronizer.
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 20000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_lvl,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic sync_q1, sync_q2;
    logic lvl, lvl_q;
    logic rise, fall;

    logic [CNT_W-1:0] cnt_q;    // cycles since the last restarting rise
    logic [CNT_W-1:0] tcnt_q;   // cycles since the last accepted edge
    logic [CNT_W-1:0] hlat_q;   // high time latched at the fall
    logic             armed_q;  // a genuine high time has been latched for this period

    logic report, enter_stuck, leave_stuck, restart, latch_high, edge_acc, expired;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PWM_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

    logic [FC_W-1:0] filt_cnt;
    logic            filt_lvl;

    // The new level is taken only after FILT_LEN consecutive samples disagree
    // with the current one. The delay is fixed, so clean H/P are unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
        end else if (sync_q2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_LAST) begin
            filt_lvl <= sync_q2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FC_W'(1);
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_q2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= lvl;
    end

    assign rise    = lvl & ~lvl_q;
    assign fall    = ~lvl & lvl_q;
    assign expired = (tcnt_q == TO_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An edge takes priority over a timeout that expires in the same cycle.
    always_comb begin
        state_d     = state_q;
        report      = 1'b0;
        enter_stuck = 1'b0;
        leave_stuck = 1'b0;
        restart     = 1'b0;
        latch_high  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    restart = 1'b1;
                end else if (expired) begin
                    state_d     = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d    = LOW;
                    latch_high = 1'b1;
                end else if (expired) begin
                    state_d     = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    restart = 1'b1;
                    report  = armed_q;
                end else if (expired) begin
                    state_d     = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d     = HIGH;
                    restart     = 1'b1;
                    leave_stuck = 1'b1;
                end else if (fall) begin
                    state_d     = LOW;
                    leave_stuck = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign edge_acc = restart | latch_high | leave_stuck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tcnt_q  <= '0;
            hlat_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            // A rise at cycle e loads 1, so the register equals the elapsed
            // cycle count when the next edge is seen.
            if (restart)             cnt_q <= CNT_ONE;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;

            if (edge_acc)            tcnt_q <= CNT_ONE;
            else if (enter_stuck)    tcnt_q <= '0;
            else if (state_q != STUCK && !expired) tcnt_q <= tcnt_q + CNT_ONE;

            if (latch_high) hlat_q <= cnt_q;

            if (latch_high)                            armed_q <= 1'b1;
            else if (restart || enter_stuck || leave_stuck) armed_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
            stuck_lvl  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= report | enter_stuck;
            if (report) begin
                high_cnt   <= hlat_q;
                period_cnt <= cnt_q;
                overflow   <= (cnt_q == CNT_MAX);
            end else if (enter_stuck) begin
                high_cnt   <= lvl ? TO_VAL : '0;
                period_cnt <= TO_VAL;
                overflow   <= 1'b0;
            end
            if (enter_stuck) begin
                stuck     <= 1'b1;
                stuck_lvl <= lvl;
            end else if (leave_stuck) begin
                stuck     <= 1'b0;
                stuck_lvl <= 1'b0;
            end
        end
    end

endmodule
